// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: round-robin AXI4-Lite arbiter, grant held for one whole read or write transaction
module axi_rr_arbiter #(
   parameter  int N_MST     = 2,
   localparam int WIDTH_MST = (N_MST > 1) ? $clog2(N_MST) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [N_MST-1:0]      m_arvalid_i,
   output logic [N_MST-1:0]      m_aready_o,
   input  logic [32*N_MST-1:0]   m_araddr_i,
   output logic [N_MST-1:0]      m_rvalid_o,
   input  logic [N_MST-1:0]      m_rready_i,
   output logic [32*N_MST-1:0]   m_rdata_o,
   output logic [2*N_MST-1:0]    m_rresp_o,
   input  logic [N_MST-1:0]      m_awvalid_i,
   output logic [N_MST-1:0]      m_awready_o,
   input  logic [32*N_MST-1:0]   m_awaddr_i,
   input  logic [N_MST-1:0]      m_wvalid_i,
   output logic [N_MST-1:0]      m_wready_o,
   input  logic [32*N_MST-1:0]   m_wdata_i,
   input  logic [4*N_MST-1:0]    m_wstrb_i,
   output logic [N_MST-1:0]      m_bvalid_o,
   input  logic [N_MST-1:0]      m_bready_i,
   output logic [2*N_MST-1:0]    m_bresp_o,
   output logic                  s_arvalid_o,
   input  logic                  s_aready_i,
   output logic [31:0]           s_araddr_o,
   input  logic                  s_rvalid_i,
   output logic                  s_rready_o,
   input  logic [31:0]           s_rdata_i,
   input  logic [1:0]            s_rresp_i,
   output logic                  s_awvalid_o,
   input  logic                  s_awready_i,
   output logic [31:0]           s_awaddr_o,
   output logic                  s_wvalid_o,
   input  logic                  s_wready_i,
   output logic [31:0]           s_wdata_o,
   output logic [3:0]            s_wstrb_o,
   input  logic                  s_bvalid_i,
   output logic                  s_bready_o,
   input  logic [1:0]            s_bresp_i,
   output logic [N_MST-1:0]      grant_o
);
   typedef enum logic [2:0] {IDLE, AR, R, WR, B} state_t;
   state_t               state_q, state_d;
   logic [WIDTH_MST-1:0] grant_idx_q, grant_idx_d, last_q, last_d, pick, idx;
   logic                 aw_done_q, aw_done_d, w_done_q, w_done_d, aw_hs, w_hs;
   logic [N_MST-1:0]     req;
   logic [31:0]          g;
   assign req = m_arvalid_i | m_awvalid_i;
   assign g   = 32'(grant_idx_q);
   // scan from last+N down to last+1 so the nearest requester after last_q wins
   always_comb begin
      pick = '0;
      idx  = '0;
      for (int k = N_MST; k >= 1; k--) begin
         idx = WIDTH_MST'((int'(last_q) + k) % N_MST);
         if (req[idx]) pick = idx;
      end
   end
   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      last_d      = last_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      aw_hs       = 1'b0;
      w_hs        = 1'b0;
      grant_o     = '0;
      m_aready_o  = '0;
      m_rvalid_o  = '0;
      m_rdata_o   = '0;
      m_rresp_o   = '0;
      m_awready_o = '0;
      m_wready_o  = '0;
      m_bvalid_o  = '0;
      m_bresp_o   = '0;
      s_arvalid_o = 1'b0;
      s_araddr_o  = '0;
      s_rready_o  = 1'b0;
      s_awvalid_o = 1'b0;
      s_awaddr_o  = '0;
      s_wvalid_o  = 1'b0;
      s_wdata_o   = '0;
      s_wstrb_o   = '0;
      s_bready_o  = 1'b0;
      case (state_q)
         IDLE: if (|req) begin
            grant_idx_d = pick;
            state_d     = m_arvalid_i[pick] ? AR : WR;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
         end
         AR: begin
            grant_o[grant_idx_q]    = 1'b1;
            s_arvalid_o             = m_arvalid_i[grant_idx_q];
            s_araddr_o              = m_araddr_i[g*32 +: 32];
            m_aready_o[grant_idx_q] = s_aready_i;
            if (s_aready_i & m_arvalid_i[grant_idx_q]) state_d = R;
         end
         R: begin
            grant_o[grant_idx_q]    = 1'b1;
            m_rvalid_o[grant_idx_q] = s_rvalid_i;
            m_rdata_o[g*32 +: 32]   = s_rdata_i;
            m_rresp_o[g*2 +: 2]     = s_rresp_i;
            s_rready_o              = m_rready_i[grant_idx_q];
            if (s_rvalid_i & m_rready_i[grant_idx_q]) begin
               last_d  = grant_idx_q;
               state_d = IDLE;
            end
         end
         WR: begin
            grant_o[grant_idx_q]     = 1'b1;
            s_awvalid_o              = m_awvalid_i[grant_idx_q] & ~aw_done_q;
            m_awready_o[grant_idx_q] = s_awready_i & ~aw_done_q;
            s_awaddr_o               = m_awaddr_i[g*32 +: 32];
            s_wvalid_o               = m_wvalid_i[grant_idx_q] & ~w_done_q;
            m_wready_o[grant_idx_q]  = s_wready_i & ~w_done_q;
            s_wdata_o                = m_wdata_i[g*32 +: 32];
            s_wstrb_o                = m_wstrb_i[g*4 +: 4];
            aw_hs                    = s_awvalid_o & s_awready_i;
            w_hs                     = s_wvalid_o & s_wready_i;
            aw_done_d                = aw_done_q | aw_hs;
            w_done_d                 = w_done_q | w_hs;
            if (aw_done_d & w_done_d) state_d = B;
         end
         B: begin
            grant_o[grant_idx_q]    = 1'b1;
            m_bvalid_o[grant_idx_q] = s_bvalid_i;
            m_bresp_o[g*2 +: 2]     = s_bresp_i;
            s_bready_o              = m_bready_i[grant_idx_q];
            if (s_bvalid_i & m_bready_i[grant_idx_q]) begin
               last_d  = grant_idx_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         grant_idx_q <= '0;
         last_q      <= WIDTH_MST'(N_MST - 1);
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         last_q      <= last_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
      end
   end
endmodule
